sdpram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that sequences one external `SDPRAM_SINGLECLK` instance as a first-word-fall-through FIFO. It owns the RAM write and read ports and manages pointers, full/empty and occupancy. It hides the RAM read latency behind a small output buffer, so the consumer sees a valid/ready stream at one word per clock. It sits between a producer stream and a consumer stream inside the same clock domain as the RAM.

---
 rtl/sdpram_fifo_ctrl.sv | 157 +++++++++++++++
 tb/tb_sdpram_fifo_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdpram_fifo_ctrl
// Purpose  : First-word-fall-through FIFO controller around one external
//            simple-dual-port single-clock RAM. Owns the RAM write and read
//            ports, keeps wrap-bit pointers, and hides the RAM read latency
//            behind a small output buffer so the consumer sees a one-word-
//            per-clock valid/ready stream.
// Ports    : CLK_I          - clock (shared with the RAM)
//            RESET_N_I      - asynchronous active-low reset
//            S_DATA_I/S_VALID_I/S_READY_O   - producer stream
//            M_DATA_O/M_VALID_O/M_READY_I   - consumer stream (FIFO head)
//            RAM_WADDR_O/RAM_WENABLE_O/RAM_WDATA_O - RAM write port
//            RAM_RADDR_O/RAM_RENABLE_O/RAM_RDATA_I - RAM read port
//            LEVEL_O/FULL_O/EMPTY_O - RAM occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module sdpram_fifo_ctrl #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "FALSE"
) (
  input  logic                  CLK_I,
  input  logic                  RESET_N_I,
  input  logic [DATA_WIDTH-1:0] S_DATA_I,
  input  logic                  S_VALID_I,
  output logic                  S_READY_O,
  output logic [DATA_WIDTH-1:0] M_DATA_O,
  output logic                  M_VALID_O,
  input  logic                  M_READY_I,
  output logic [ADDR_WIDTH-1:0] RAM_WADDR_O,
  output logic                  RAM_WENABLE_O,
  output logic [DATA_WIDTH-1:0] RAM_WDATA_O,
  output logic [ADDR_WIDTH-1:0] RAM_RADDR_O,
  output logic                  RAM_RENABLE_O,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA_I,
  output logic [ADDR_WIDTH:0]   LEVEL_O,
  output logic                  FULL_O,
  output logic                  EMPTY_O
);

  // RAM read latency in cycles.
  localparam int c_LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;
  // Counter width for in-flight + buffered words (at most 2*c_LAT+1 = 5).
  localparam int c_CNT_W = 3;
  localparam logic [ADDR_WIDTH:0] c_FULL_LVL = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [c_LAT-1:0]      r_inflight;
  logic [DATA_WIDTH-1:0] r_buf [c_LAT+1];
  logic [c_CNT_W-1:0]    r_bcnt;
  logic                  r_mvalid;

  logic [ADDR_WIDTH:0]   w_level;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_capture;
  logic [c_CNT_W-1:0]    w_nflight;
  logic [c_CNT_W-1:0]    w_bcnt_nxt;
  logic [c_CNT_W-1:0]    w_widx;
  logic [DATA_WIDTH-1:0] w_buf_nxt [c_LAT+1];

  // Status purely from registered pointers, so a write is never visible to
  // read issue in its own cycle and a freed slot only shows up next cycle.
  assign w_level = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_level == c_FULL_LVL);

  assign w_wr  = S_VALID_I && !w_full && RESET_N_I;
  assign w_pop = r_mvalid && M_READY_I;

  always_comb begin
    w_nflight = '0;
    for (int i = 0; i < c_LAT; i++) begin
      w_nflight = w_nflight + c_CNT_W'(r_inflight[i]);
    end
  end

  // Credit: in-flight plus buffered words (after this cycle's pop) must stay
  // within the c_LAT+1 buffer entries. Pop is added on the right-hand side
  // instead of subtracted on the left to avoid unsigned underflow.
  assign w_issue = RESET_N_I && !w_empty &&
                   ((w_nflight + r_bcnt) < (c_CNT_W'(c_LAT + 1) + c_CNT_W'(w_pop)));

  // The oldest in-flight read reaches the tail of the shift register exactly
  // c_LAT edges after issue, which is when its RAM data is valid.
  assign w_capture  = r_inflight[c_LAT-1];
  assign w_bcnt_nxt = r_bcnt + c_CNT_W'(w_capture) - c_CNT_W'(w_pop);
  assign w_widx     = r_bcnt - c_CNT_W'(w_pop);

  // Output buffer kept as a shift queue: entry 0 is always the head, so
  // M_DATA_O comes straight from a register.
  always_comb begin
    for (int i = 0; i <= c_LAT; i++) begin
      w_buf_nxt[i] = r_buf[i];
    end
    if (w_pop) begin
      for (int i = 0; i < c_LAT; i++) begin
        w_buf_nxt[i] = r_buf[i+1];
      end
    end
    if (w_capture) begin
      for (int i = 0; i <= c_LAT; i++) begin
        if (w_widx == c_CNT_W'(i)) begin
          w_buf_nxt[i] = RAM_RDATA_I;
        end
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RESET_N_I) begin
    if (!RESET_N_I) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= '0;
      r_bcnt     <= '0;
      r_mvalid   <= 1'b0;
      for (int i = 0; i <= c_LAT; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_inflight[0] <= w_issue;
      for (int i = 1; i < c_LAT; i++) begin
        r_inflight[i] <= r_inflight[i-1];
      end
      r_bcnt   <= w_bcnt_nxt;
      r_mvalid <= (w_bcnt_nxt != '0);
      for (int i = 0; i <= c_LAT; i++) begin
        r_buf[i] <= w_buf_nxt[i];
      end
    end
  end

  assign S_READY_O     = !w_full;
  assign RAM_WENABLE_O = w_wr;
  assign RAM_WADDR_O   = r_wptr[ADDR_WIDTH-1:0];
  assign RAM_WDATA_O   = S_DATA_I;
  assign RAM_RENABLE_O = w_issue;
  assign RAM_RADDR_O   = r_rptr[ADDR_WIDTH-1:0];
  assign M_DATA_O      = r_buf[0];
  assign M_VALID_O     = r_mvalid;
  assign LEVEL_O       = w_level;
  assign FULL_O        = w_full;
  assign EMPTY_O       = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_sdpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdpram_fifo_ctrl
// Purpose  : Self-checking bench for sdpram_fifo_ctrl. Two controllers, one
//            per OUTPUT_REG setting (index 0: read latency 1, index 1: read
//            latency 2), share clock, reset and stimulus; each drives its own
//            behavioural RAM. A transaction scoreboard per controller checks
//            order, drops, duplicates and stall stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] s_data;
  logic       s_valid;
  logic       m_ready;

  logic       s_ready [2];
  logic [7:0] m_data  [2];
  logic       m_valid [2];
  logic [8:0] waddr   [2];
  logic       wen     [2];
  logic [7:0] wdata   [2];
  logic [8:0] raddr   [2];
  logic       ren     [2];
  logic [7:0] rdata   [2];
  logic [9:0] level   [2];
  logic       full    [2];
  logic       empty   [2];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .OUTPUT_REG("FALSE")) u_dut0 (
    .CLK_I(clk), .RESET_N_I(rst_n),
    .S_DATA_I(s_data), .S_VALID_I(s_valid), .S_READY_O(s_ready[0]),
    .M_DATA_O(m_data[0]), .M_VALID_O(m_valid[0]), .M_READY_I(m_ready),
    .RAM_WADDR_O(waddr[0]), .RAM_WENABLE_O(wen[0]), .RAM_WDATA_O(wdata[0]),
    .RAM_RADDR_O(raddr[0]), .RAM_RENABLE_O(ren[0]), .RAM_RDATA_I(rdata[0]),
    .LEVEL_O(level[0]), .FULL_O(full[0]), .EMPTY_O(empty[0])
  );

  sdpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(9), .OUTPUT_REG("TRUE")) u_dut1 (
    .CLK_I(clk), .RESET_N_I(rst_n),
    .S_DATA_I(s_data), .S_VALID_I(s_valid), .S_READY_O(s_ready[1]),
    .M_DATA_O(m_data[1]), .M_VALID_O(m_valid[1]), .M_READY_I(m_ready),
    .RAM_WADDR_O(waddr[1]), .RAM_WENABLE_O(wen[1]), .RAM_WDATA_O(wdata[1]),
    .RAM_RADDR_O(raddr[1]), .RAM_RENABLE_O(ren[1]), .RAM_RDATA_I(rdata[1]),
    .LEVEL_O(level[1]), .FULL_O(full[1]), .EMPTY_O(empty[1])
  );

  // Behavioural RAMs: registered read, plus an output register for latency 2.
  logic [7:0] mem0 [512];
  logic [7:0] mem1 [512];
  logic [7:0] q0, q1a, q1b;
  always @(posedge clk) begin
    if (wen[0]) mem0[waddr[0]] <= wdata[0];
    if (ren[0]) q0 <= mem0[raddr[0]];
  end
  always @(posedge clk) begin
    if (wen[1]) mem1[waddr[1]] <= wdata[1];
    if (ren[1]) q1a <= mem1[raddr[1]];
    q1b <= q1a;
  end
  assign rdata[0] = q0;
  assign rdata[1] = q1b;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ------------------------------------------------------------------
  // Scoreboard: accepted words are appended to a per-controller list and
  // every pop must return the oldest unread one. Reset discards all.
  // ------------------------------------------------------------------
  logic [7:0] sbm [2][4096];
  int         wr_cnt [2] = '{0, 0};
  int         rd_cnt [2] = '{0, 0};
  logic       hold_v [2] = '{1'b0, 1'b0};
  logic [7:0] hold_d [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rd_cnt[i] = wr_cnt[i];
        hold_v[i] = 1'b0;
      end else begin
        if (hold_v[i]) begin
          check("stall_valid", 32'(m_valid[i]), 32'd1);
          check("stall_data", 32'(m_data[i]), 32'(hold_d[i]));
        end
        if (wen[i]) check("wr_data", 32'(wdata[i]), 32'(s_data));
        if (wen[i] && ren[i]) check("rw_addr_differ", 32'(waddr[i] != raddr[i]), 32'd1);
        if (s_valid && s_ready[i]) begin
          sbm[i][wr_cnt[i] % 4096] = s_data;
          wr_cnt[i]++;
        end
        if (m_valid[i] && m_ready) begin
          check("pop_has_word", 32'(rd_cnt[i] < wr_cnt[i]), 32'd1);
          check("pop_order", 32'(m_data[i]), 32'(sbm[i][rd_cnt[i] % 4096]));
          rd_cnt[i]++;
        end
        hold_v[i] = m_valid[i] && !m_ready;
        hold_d[i] = m_data[i];
      end
    end
  end

  // Drain both FIFOs; done once both are idle for several cycles so that
  // no read is still in flight.
  task automatic drain(input string nm);
    int quiet;
    quiet   = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 800 && quiet < 5; c++) begin
      @(negedge clk);
      if (empty[0] && empty[1] && !m_valid[0] && !m_valid[1]) quiet++;
      else quiet = 0;
      tick();
    end
    check({nm, "_idle"}, 32'(quiet >= 5), 32'd1);
    for (int i = 0; i < 2; i++) check({nm, "_sb_empty"}, 32'(rd_cnt[i]), 32'(wr_cnt[i]));
  endtask

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       e_srdy;
    logic [9:0] e_lvl;
    logic       e_wen;
    logic       e_ren;
    logic       e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc [2];
    int popped [2];
    logic started [2];
    int k;

    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;

    //            sv    sd     mr   srdy  lvl     wen   ren   v0    d0     v1    d1
    tbl[0]  = '{1'b1, 8'h46, 1'b0, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 8'h46, 1'b1, 8'h46};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[6]  = '{1'b1, 8'h11, 1'b1, 1'b1, 10'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'h22, 1'b1, 1'b1, 10'd1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 10'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 8'h11};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

    // ---------------- reset state ----------------
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_empty", 32'(empty[i]), 32'd1);
      check("rst_full", 32'(full[i]), 32'd0);
      check("rst_level", 32'(level[i]), 32'd0);
      check("rst_s_ready", 32'(s_ready[i]), 32'd1);
      check("rst_m_valid", 32'(m_valid[i]), 32'd0);
    end
    tick();

    // ---------------- vector table ----------------
    for (int r = 0; r < 13; r++) begin
      s_valid = tbl[r].sv;
      s_data  = tbl[r].sd;
      m_ready = tbl[r].mr;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("vec_s_ready", 32'(s_ready[i]), 32'(tbl[r].e_srdy));
        check("vec_level", 32'(level[i]), 32'(tbl[r].e_lvl));
        check("vec_empty", 32'(empty[i]), 32'(tbl[r].e_lvl == 10'd0));
        check("vec_wen", 32'(wen[i]), 32'(tbl[r].e_wen));
        check("vec_ren", 32'(ren[i]), 32'(tbl[r].e_ren));
      end
      check("vec_m_valid0", 32'(m_valid[0]), 32'(tbl[r].e_v0));
      check("vec_m_valid1", 32'(m_valid[1]), 32'(tbl[r].e_v1));
      if (tbl[r].e_v0) check("vec_m_data0", 32'(m_data[0]), 32'(tbl[r].e_d0));
      if (tbl[r].e_v1) check("vec_m_data1", 32'(m_data[1]), 32'(tbl[r].e_d1));
      tick();
    end

    // ---------------- fill with consumer stalled ----------------
    acc = '{0, 0};
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int c = 0; c < 600; c++) begin
      s_data = 8'((70 + 2 * c) & 255);
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (s_ready[i]) acc[i]++;
      tick();
    end
    s_valid = 1'b0;
    @(negedge clk);
    // RAM holds 512, buffer holds latency+1 more.
    check("fill_accepted0", 32'(acc[0]), 32'd514);
    check("fill_accepted1", 32'(acc[1]), 32'd515);
    for (int i = 0; i < 2; i++) begin
      check("fill_full", 32'(full[i]), 32'd1);
      check("fill_level", 32'(level[i]), 32'd512);
      check("fill_s_ready", 32'(s_ready[i]), 32'd0);
      check("fill_m_valid", 32'(m_valid[i]), 32'd1);
    end
    tick();

    // Single pop: read issues this cycle, ready rises only next cycle.
    m_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("pulse_ren", 32'(ren[i]), 32'd1);
      check("pulse_s_ready_same", 32'(s_ready[i]), 32'd0);
    end
    tick();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hAB;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("pulse_s_ready_next", 32'(s_ready[i]), 32'd1);
      check("pulse_wen", 32'(wen[i]), 32'd1);
      check("pulse_level", 32'(level[i]), 32'd511);
    end
    tick();
    s_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("pulse_refull", 32'(full[i]), 32'd1);
      check("pulse_relevel", 32'(level[i]), 32'd512);
    end
    tick();
    drain("drain_fill");

    // ---------------- continuous stream 3 x 512 ----------------
    do_reset();
    popped  = '{0, 0};
    started = '{1'b0, 1'b0};
    k = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 1536 + 12; c++) begin
      s_valid = (k < 1536);
      s_data  = 8'((70 + 2 * k) & 255);
      @(negedge clk);
      if (s_valid) begin
        for (int i = 0; i < 2; i++) check("stream_s_ready", 32'(s_ready[i]), 32'd1);
        k++;
      end
      for (int i = 0; i < 2; i++) begin
        if (started[i] && popped[i] < 1536) check("stream_gap", 32'(m_valid[i]), 32'd1);
        if (m_valid[i]) begin
          check("stream_data", 32'(m_data[i]), 32'((70 + 2 * popped[i]) % 256));
          popped[i]++;
          started[i] = 1'b1;
        end
      end
      tick();
    end
    for (int i = 0; i < 2; i++) check("stream_count", 32'(popped[i]), 32'd1536);

    // ---------------- reset mid-stream ----------------
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_data = 8'(c + 1);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("midrst_m_valid", 32'(m_valid[i]), 32'd0);
      check("midrst_wen", 32'(wen[i]), 32'd0);
      check("midrst_ren", 32'(ren[i]), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_empty", 32'(empty[i]), 32'd1);
      check("post_rst_full", 32'(full[i]), 32'd0);
      check("post_rst_level", 32'(level[i]), 32'd0);
      check("post_rst_s_ready", 32'(s_ready[i]), 32'd1);
      check("post_rst_m_valid", 32'(m_valid[i]), 32'd0);
    end
    tick();
    s_valid = 1'b1;
    s_data  = 8'h10;
    tick();
    s_valid = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("post_rst_new_valid", 32'(m_valid[i]), 32'd1);
      check("post_rst_new_data", 32'(m_data[i]), 32'h10);
    end
    tick();
    m_ready = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("post_rst_no_stale", 32'(m_valid[i]), 32'd0);
      tick();
    end

    // ---------------- random stalls ----------------
    for (int c = 0; c < 2000; c++) begin
      s_valid = ($urandom_range(0, 99) < ((c < 1000) ? 90 : 40));
      m_ready = ($urandom_range(0, 99) < ((c < 1000) ? 25 : 70));
      s_data  = 8'($urandom_range(0, 255));
      tick();
    end
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
